// File: rtl/cpu_defines.sv
// Shared CPU-wide constants and the fetch-stage state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_defines;

  // Architectural no-op presented on bubble cycles.
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;

  // PC loaded on reset unless the instantiating core overrides it.
  localparam logic [31:0] DEFAULT_RESET_ADDRESS = 32'h0000_0000;

  // S_REQ: a fetch is outstanding at pc.
  // S_HOLD: the instruction at pc is parked in the hold buffer.
  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/stage_if_if.sv
// Bundle of fetch-stage signals: instruction-memory handshake plus the
// hazard/branch inputs from ID and the outputs towards the IF/ID latch.
// master = fetch stage, slave = the surrounding pipeline and memory.
interface stage_if_if;

  // Hazard unit / ID stage
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_address;

  // Instruction memory
  logic        mem_request;
  logic [31:0] mem_address;
  logic        mem_ready;
  logic [31:0] mem_data;

  // Towards the IF/ID latch
  logic        if_valid;
  logic [31:0] if_program_counter;
  logic [31:0] if_instruction;

  modport master (
    input  stall, branch_flag, branch_address, mem_ready, mem_data,
    output mem_request, mem_address, if_valid, if_program_counter, if_instruction
  );

  modport slave (
    output stall, branch_flag, branch_address, mem_ready, mem_data,
    input  mem_request, mem_address, if_valid, if_program_counter, if_instruction
  );

endinterface

// File: rtl/stage_if.sv
// Instruction fetch: owns the PC, fetches words over request/ready, honours delay slots.
// Latency: zero-cycle path from mem_data to the IF outputs; k bubbles for a k-cycle memory.
// Backpressure: a stalled delivery is parked in a one-entry hold buffer, no re-fetch.
module stage_if
  import cpu_defines::*;
#(
  parameter logic [31:0] RESET_ADDRESS = DEFAULT_RESET_ADDRESS
) (
  input  logic       clock,
  input  logic       reset,
  stage_if_if.master bus
);

  // Architectural state
  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_hold_instruction;
  logic         r_redirect_valid;
  logic [31:0]  r_redirect_address;

  // Next-state values
  fetch_state_t w_state_d;
  logic [31:0]  w_pc_d;
  logic [31:0]  w_hold_instruction_d;
  logic         w_redirect_valid_d;
  logic [31:0]  w_redirect_address_d;

  // Decode helpers
  logic [31:0]  w_target;
  logic         w_branch;
  logic         w_delivering;
  logic         w_advance;
  logic [31:0]  w_next_pc;

  // Register update: synchronous reset drops any in-flight fetch and pending redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state            <= S_REQ;
      r_pc               <= RESET_ADDRESS & ~32'h3;
      r_hold_instruction <= NOP_INSTRUCTION;
      r_redirect_valid   <= 1'b0;
      r_redirect_address <= 32'h0;
    end else begin
      r_state            <= w_state_d;
      r_pc               <= w_pc_d;
      r_hold_instruction <= w_hold_instruction_d;
      r_redirect_valid   <= w_redirect_valid_d;
      r_redirect_address <= w_redirect_address_d;
    end
  end

  // Fetch FSM, next-PC selection and IF outputs.
  always_comb begin
    w_state_d            = r_state;
    w_pc_d               = r_pc;
    w_hold_instruction_d = r_hold_instruction;
    w_redirect_valid_d   = r_redirect_valid;
    w_redirect_address_d = r_redirect_address;

    bus.mem_request        = 1'b0;
    bus.mem_address        = r_pc;
    bus.if_valid           = 1'b0;
    bus.if_program_counter = 32'h0;
    bus.if_instruction     = NOP_INSTRUCTION;

    // Low target bits are not part of a word address; drop them here.
    w_target = bus.branch_address & ~32'h3;
    // A branch seen during a stall is replayed by ID later, so only act unstalled.
    w_branch = bus.branch_flag & ~bus.stall;

    // Fresh branch beats a pending redirect (the illegal branch-in-delay-slot
    // case simply lets the newer target win).
    if (w_branch) begin
      w_next_pc = w_target;
    end else if (r_redirect_valid) begin
      w_next_pc = r_redirect_address;
    end else begin
      w_next_pc = r_pc + 32'd4;
    end

    w_delivering = 1'b0;

    if (!reset) begin
      unique case (r_state)
        S_REQ: begin
          bus.mem_request = 1'b1;
          if (bus.mem_ready) begin
            w_delivering           = 1'b1;
            bus.if_valid           = 1'b1;
            bus.if_program_counter = r_pc;
            bus.if_instruction     = bus.mem_data;
            if (bus.stall) begin
              w_hold_instruction_d = bus.mem_data;
              w_state_d            = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          w_delivering           = 1'b1;
          bus.if_valid           = 1'b1;
          bus.if_program_counter = r_pc;
          bus.if_instruction     = r_hold_instruction;
          if (!bus.stall) begin
            w_state_d = S_REQ;
          end
        end
        default: begin
          w_state_d = S_REQ;
        end
      endcase
    end

    w_advance = w_delivering & ~bus.stall;

    if (w_advance) begin
      // The delivered word is the delay slot of any branch resolved so far.
      w_pc_d             = w_next_pc;
      w_redirect_valid_d = 1'b0;
    end else if (w_branch && !reset) begin
      // Branch arrived during a bubble: the delay slot is still to come.
      w_redirect_valid_d   = 1'b1;
      w_redirect_address_d = w_target;
    end
  end

endmodule
